bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq_if.sv | 16 +
 rtl/bin2bcd_seq.sv | 119 +++++++++++
 tb/tb_bin2bcd_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/done handshake and result bundle for bin2bcd_seq
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     blank;
  logic                  ovf;

  modport master (output start, bin_in, input busy, done, bcd_out, blank, ovf);
  modport slave  (input start, bin_in, output busy, done, bcd_out, blank, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD with leading-zero blank mask
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          resetn,
  bin2bcd_seq_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [BIN_W-1:0]  shreg, shreg_nxt;
  logic [BW-1:0]     scr, scr_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              ovf_s, ovf_s_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic [BW-1:0]     bcd_q, bcd_nxt;
  logic [DIGITS-1:0] blank_q, blank_nxt;
  logic              ovf_q, ovf_nxt;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     shifted;
  logic [DIGITS-1:0] mask;
  logic              zero_above;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      shreg   <= '0;
      scr     <= '0;
      cnt     <= '0;
      ovf_s   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      scr     <= scr_nxt;
      cnt     <= cnt_nxt;
      ovf_s   <= ovf_s_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      bcd_q   <= bcd_nxt;
      blank_q <= blank_nxt;
      ovf_q   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    scr_nxt   = scr;
    cnt_nxt   = cnt;
    ovf_s_nxt = ovf_s;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    bcd_nxt   = bcd_q;
    blank_nxt = blank_q;
    ovf_nxt   = ovf_q;

    // Add-3 per nibble with no inter-nibble carry, then shift one bit in from the binary side.
    adj = scr;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
    shifted = {adj[BW-2:0], shreg[BIN_W-1]};

    // A digit is blanked only when it and every digit above it are zero; digit 0 always shows.
    mask       = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (shifted[4*i +: 4] == 4'd0);
      mask[i]    = zero_above;
    end

    case (state)
      IDLE: begin
        if (bus.start) begin
          shreg_nxt = bus.bin_in;
          scr_nxt   = '0;
          ovf_s_nxt = 1'b0;
          cnt_nxt   = CW'(BIN_W);
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        scr_nxt   = shifted;
        shreg_nxt = shreg << 1;
        ovf_s_nxt = ovf_s | adj[BW-1];
        cnt_nxt   = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          bcd_nxt   = shifted;
          ovf_nxt   = ovf_s | adj[BW-1];
          blank_nxt = mask;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.blank   = blank_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed and sweep checks for bin2bcd_seq at DIGITS=3 and DIGITS=2
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [11:0] prev3 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq_if #(.BIN_W(8), .DIGITS(3)) b3 ();
  bin2bcd_seq_if #(.BIN_W(8), .DIGITS(2)) b2 ();

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (.clk(clk), .resetn(resetn), .bus(b3.slave));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (.clk(clk), .resetn(resetn), .bus(b2.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One conversion on the 3-digit instance; optional poke raises start mid-conversion with another value.
  task automatic run3(input string tag, input logic [7:0] v, input logic [11:0] eb,
                      input logic [2:0] ebl, input bit poke);
    int busy_n = 0;
    int holdbad = 0;
    int extra = 0;
    bit got = 0;
    @(negedge clk);
    b3.start = 1'b1; b3.bin_in = v;
    @(negedge clk);
    b3.start = 1'b0; b3.bin_in = ~v;
    for (int c = 0; c < 20 && !got; c++) begin
      if (b3.done) got = 1;
      else begin
        if (b3.busy) busy_n++;
        if (b3.bcd_out !== prev3) holdbad++;
        if (poke && c == 3) begin b3.start = 1'b1; b3.bin_in = 8'd5; end
        else b3.start = 1'b0;
        @(negedge clk);
      end
    end
    b3.start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_len"}, 32'(busy_n), 32'd8);
    check({tag, "_hold"}, 32'(holdbad), 32'd0);
    check({tag, "_bcd"}, 32'(b3.bcd_out), 32'(eb));
    check({tag, "_blank"}, 32'(b3.blank), 32'(ebl));
    check({tag, "_ovf"}, 32'(b3.ovf), 32'd0);
    check({tag, "_busy_in_done"}, 32'(b3.busy), 32'd0);
    prev3 = eb;
    @(negedge clk);
    check({tag, "_done_width"}, 32'(b3.done), 32'd0);
    if (poke) begin
      for (int c = 0; c < 12; c++) begin
        if (b3.done) extra++;
        @(negedge clk);
      end
      check({tag, "_no_extra_done"}, 32'(extra), 32'd0);
      check({tag, "_bcd_kept"}, 32'(b3.bcd_out), 32'(eb));
    end
  endtask

  task automatic run2(input string tag, input logic [7:0] v, input logic [7:0] eb,
                      input logic [1:0] ebl, input logic eovf);
    bit got = 0;
    @(negedge clk);
    b2.start = 1'b1; b2.bin_in = v;
    @(negedge clk);
    b2.start = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (b2.done) got = 1;
      else @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_bcd"}, 32'(b2.bcd_out), 32'(eb));
    check({tag, "_blank"}, 32'(b2.blank), 32'(ebl));
    check({tag, "_ovf"}, 32'(b2.ovf), 32'(eovf));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  vals [3];
    logic [11:0] exps [3];
    logic [2:0]  bls  [3];
    int last_done;
    int dones;
    bit got;

    b3.start = 1'b0; b3.bin_in = '0;
    b2.start = 1'b0; b2.bin_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(b3.busy), 32'd0);
    check("rst_done", 32'(b3.done), 32'd0);
    check("rst_bcd", 32'(b3.bcd_out), 32'd0);
    check("rst_blank", 32'(b3.blank), 32'b110);
    check("rst_ovf", 32'(b3.ovf), 32'd0);
    check("rst_blank_d2", 32'(b2.blank), 32'b10);
    resetn = 1'b1;

    run3("v255", 8'd255, 12'h255, 3'b000, 1'b0);
    run3("v0",   8'd0,   12'h000, 3'b110, 1'b0);
    run3("v100", 8'd100, 12'h100, 3'b000, 1'b0);
    run3("v9",   8'd9,   12'h009, 3'b110, 1'b0);
    run3("poke", 8'd100, 12'h100, 3'b000, 1'b1);

    // Back-to-back with start held high; bin_in is scrambled while busy to catch re-sampling.
    vals = '{8'd37, 8'd42, 8'd199};
    exps = '{12'h037, 12'h042, 12'h199};
    bls  = '{3'b100, 3'b100, 3'b000};
    last_done = 0;
    @(negedge clk);
    b3.start = 1'b1; b3.bin_in = vals[0];
    for (int k = 0; k < 3; k++) begin
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (c == 0) b3.bin_in = 8'd250;
        if (b3.done) got = 1;
      end
      check($sformatf("b2b%0d_done_seen", k), 32'(got), 32'd1);
      check($sformatf("b2b%0d_bcd", k), 32'(b3.bcd_out), 32'(exps[k]));
      check($sformatf("b2b%0d_blank", k), 32'(b3.blank), 32'(bls[k]));
      if (k > 0) check($sformatf("b2b%0d_period", k), 32'(cyc - last_done), 32'd9);
      last_done = cyc;
      if (k < 2) b3.bin_in = vals[k+1];
      else b3.start = 1'b0;
    end
    prev3 = 12'h199;
    @(negedge clk);

    // Reset lands on the fourth SHIFT edge of a 255 conversion.
    b3.start = 1'b1; b3.bin_in = 8'd255;
    @(negedge clk);
    b3.start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(b3.busy), 32'd0);
    check("abort_done", 32'(b3.done), 32'd0);
    check("abort_bcd", 32'(b3.bcd_out), 32'd0);
    check("abort_blank", 32'(b3.blank), 32'b110);
    resetn = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (b3.done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    prev3 = 12'h000;
    run3("v128", 8'd128, 12'h128, 3'b000, 1'b0);

    run2("d2_200", 8'd200, 8'h00, 2'b10, 1'b1);
    run2("d2_99",  8'd99,  8'h99, 2'b00, 1'b0);
    run2("d2_255", 8'd255, 8'h55, 2'b00, 1'b1);
    run2("d2_9",   8'd9,   8'h09, 2'b10, 1'b0);

    for (int v = 0; v < 256; v++) begin
      logic [11:0] e;
      logic [2:0]  bl;
      e  = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      bl = {v < 100, v < 10, 1'b0};
      run3($sformatf("sweep%0d", v), 8'(v), e, bl, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
